imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the CPU instruction memory: receives a byte stream from the host/boot link and assembles big-endian 32-bit instruction words.
- Writes each word into the writable instruction memory through a word-aligned byte-address port, matching the fetch-side addressing (word index = addr[7:2]).
- Holds the pipeline CPU stalled while loading, verifies a header and an XOR checksum, then releases the CPU.

Parameters:
- DEPTH, 64, instruction memory depth in words; legal word counts are 1..DEPTH
- IDX_W, 6, word index width, equal to log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address {24'b0, idx, 2'b00}
- wr_data  out  32  assembled instruction word
- cpu_hold  out  1  stall/reset request to the CPU while loading
- done  out  1  load completed with a good checksum (level)
- err  out  1  load failed (level)

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs are 0: byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err. Internal byte counter, word index and checksum are cleared.
- Transfer rule: a byte is consumed only in a cycle where byte_valid && byte_ready. byte_in is ignored otherwise, and byte_valid may drop at any time without penalty.
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: byte_ready=0, cpu_hold=0.
  - start -> HDR. On entry, cpu_hold rises the next cycle; done and err clear.
- HDR: byte_ready=1. The accepted byte is the word count N.
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N, set idx=0, byte count=0, checksum=0, and go to DATA.
  - The header byte is not included in the checksum.
- DATA: byte_ready=1. Each accepted byte:
  - shifts into the word register MSB-first (first byte -> bits 31:24);
  - XORs into the checksum.
  - On the 4th byte of a word -> WRITE.
- WRITE: lasts exactly one cycle.
  - byte_ready=0, wr_en=1, wr_addr={idx,2'b00}, wr_data=assembled word.
  - Latency: 4th byte accepted in cycle t -> wr_en in cycle t+1.
  - Then: if idx==N-1 -> CSUM, else idx+1 -> DATA.
  - wr_addr and wr_data hold their last values when wr_en=0.
- CSUM: byte_ready=1. The accepted byte is compared with the running XOR.
  - Equal -> DONE; mismatch -> ERR.
- DONE: done=1, cpu_hold=0, byte_ready=0. start -> HDR (reload).
- ERR: err=1, cpu_hold=1 (CPU stays stalled on a partial image), byte_ready=0. start -> HDR.
- cpu_hold=1 in HDR, DATA, WRITE, CSUM and ERR; 0 in IDLE and DONE.
- start while in HDR/DATA/WRITE/CSUM is ignored; the load in progress continues.
- Index range: idx never exceeds N-1 ≤ DEPTH-1, so no wrap occurs. The IDX_W-bit index with DEPTH=64 covers the full memory.
- Reset mid-load aborts immediately to IDLE with cpu_hold=0. Memory contents already written are left as-is; the loader does not erase them.
- Bytes presented while byte_ready=0 (IDLE/WRITE/DONE/ERR) are not consumed. The source must hold them until accepted.

Decomposition:
- Shared package:
  - state encoding constants (IDLE..ERR);
  - IMEM_DEPTH=64 and IMEM_IDX_W=6, shared with the fetch-side instruction memory so both ends agree on addr[7:2] word indexing;
  - byte-lane order constant (big-endian).
- One natural sub-module, imem_word_asm: the 8->32 shift register with a 2-bit byte counter and XOR checksum accumulator, with clear/shift/word_full signals. The FSM stays in imem_loader.

Test Plan:
- Nominal two-word load: start; bytes 02, 00 10 04 43, 00 20 10 25, checksum 42, byte_valid held high.
  - wr_en pulses exactly twice: (wr_addr 0x00, wr_data 0x00100443) then (0x04, 0x00201025).
  - Each pulse is one cycle after that word's 4th byte.
  - done=1, err=0, cpu_hold falls after the checksum byte.
- Bad checksum: same stream with checksum 43 -> both writes occur, then err=1, done=0, cpu_hold stays 1. A later start with a good stream -> done=1.
- Illegal header: N=0x00 -> ERR, no wr_en. Separately N=0x41 -> ERR, no wr_en. N=0x40 with 256 data bytes -> last write at wr_addr 0xFC.
- Gapped valid: same stream as nominal, with byte_valid toggling randomly. Also present a byte during the WRITE cycle and check byte_ready=0 and the byte is held and consumed next cycle. Writes and data must be identical to the nominal case.
- Reset mid-load: rst_n pulled low after 5 data bytes.
  - All outputs 0 asynchronously, state IDLE.
  - Bytes offered before the next start are not consumed.
  - A fresh start loads correctly from idx 0.
- start during DATA is ignored: the load completes unchanged, with no restart at HDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// The fetch side uses the same depth and addr[7:2] word indexing.
package imem_loader_pkg;

   localparam int IMEM_DEPTH = 64;
   localparam int IMEM_IDX_W = 6;

   // First stream byte of a word lands in bits 31:24.
   localparam bit BYTE_BIG_ENDIAN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   function automatic logic hdr_legal(
      input logic [7:0] n,
      input int         depth
   );
      return (n != 8'd0) && ({24'b0, n} <= 32'(depth));
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Boot-link byte stream, instruction-memory write port and
// loader status, bundled between host side and loader.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, wr_en, wr_addr, wr_data,
      input  cpu_hold, done, err
   );

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, wr_en, wr_addr, wr_data,
      output cpu_hold, done, err
   );

endinterface

// File: rtl/imem_word_asm.sv
// 8->32 word assembler with byte counter and XOR checksum.
// o_word_full means the next shifted byte completes a word.
module imem_word_asm
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_next,
   output logic [7:0]  o_csum,
   output logic        o_word_full
);

   logic [31:0] r_word;
   logic [1:0]  r_cnt;
   logic [7:0]  r_csum;

   // Word as it will look once the incoming byte is merged.
   always_comb begin
      if (BYTE_BIG_ENDIAN)
         o_word_next = {r_word[23:0], i_byte};
      else
         o_word_next = {i_byte, r_word[31:8]};
   end

   assign o_csum      = r_csum;
   assign o_word_full = (r_cnt == 2'd3);

   // Shift, count and checksum state, cleared at each new load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_cnt  <= '0;
         r_csum <= '0;
      end else if (i_clear) begin
         r_word <= '0;
         r_cnt  <= '0;
         r_csum <= '0;
      end else if (i_shift) begin
         r_word <= o_word_next;
         r_cnt  <= r_cnt + 2'd1;
         r_csum <= r_csum ^ i_byte;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream,
// writes instruction memory and stalls the CPU until verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int IDX_W = IMEM_IDX_W
) (
   input logic         clk,
   input logic         rst_n,
   imem_loader_if.slave bus
);

   state_e             r_state;
   state_e             w_next;
   logic [IDX_W-1:0]   r_idx;
   logic [7:0]         r_last;
   logic [31:0]        r_wr_addr;
   logic [31:0]        r_wr_data;

   logic               w_byte_ready;
   logic               w_accept;
   logic               w_hdr_ok;
   logic               w_last_word;
   logic               w_clear;
   logic               w_shift;
   logic               w_wr_en;
   logic               w_hold;
   logic               w_done;
   logic               w_err;
   logic [31:0]        w_word_next;
   logic [7:0]         w_csum;
   logic               w_word_full;

   assign w_byte_ready = (r_state == ST_HDR)  ||
                         (r_state == ST_DATA) ||
                         (r_state == ST_CSUM);
   assign w_accept     = bus.byte_valid && w_byte_ready;
   assign w_hdr_ok     = hdr_legal(bus.byte_in, DEPTH);
   assign w_last_word  = ({{(8-IDX_W){1'b0}}, r_idx} == r_last);

   imem_word_asm u_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_clear),
      .i_shift     (w_shift),
      .i_byte      (bus.byte_in),
      .o_word_next (w_word_next),
      .o_csum      (w_csum),
      .o_word_full (w_word_full)
   );

   // Load sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next state and per-state outputs.
   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      w_shift = 1'b0;
      w_wr_en = 1'b0;
      w_hold  = 1'b0;
      w_done  = 1'b0;
      w_err   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next = ST_HDR;
         end
         ST_HDR: begin
            w_hold = 1'b1;
            if (w_accept) begin
               if (w_hdr_ok) begin
                  w_clear = 1'b1;
                  w_next  = ST_DATA;
               end else begin
                  w_next  = ST_ERR;
               end
            end
         end
         ST_DATA: begin
            w_hold = 1'b1;
            if (w_accept) begin
               w_shift = 1'b1;
               if (w_word_full) w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_hold  = 1'b1;
            w_wr_en = 1'b1;
            w_next  = w_last_word ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            w_hold = 1'b1;
            if (w_accept)
               w_next = (bus.byte_in == w_csum) ? ST_DONE : ST_ERR;
         end
         ST_DONE: begin
            w_done = 1'b1;
            if (bus.start) w_next = ST_HDR;
         end
         ST_ERR: begin
            w_hold = 1'b1;
            w_err  = 1'b1;
            if (bus.start) w_next = ST_HDR;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Word index, last index and write-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_last    <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         if (w_clear) begin
            r_idx  <= '0;
            r_last <= bus.byte_in - 8'd1;
         end
         if (w_shift && w_word_full) begin
            r_wr_addr <= 32'({r_idx, 2'b00});
            r_wr_data <= w_word_next;
         end
         if (w_wr_en && !w_last_word)
            r_idx <= r_idx + IDX_W'(1);
      end
   end

   assign bus.byte_ready = w_byte_ready;
   assign bus.wr_en      = w_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.cpu_hold   = w_hold;
   assign bus.done       = w_done;
   assign bus.err        = w_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level
// reference model of header, big-endian words and XOR checksum.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   imem_loader_if bus();

   imem_loader #(
      .DEPTH (IMEM_DEPTH),
      .IDX_W (IMEM_IDX_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  stim[$];
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   logic        wp[$];
   int          cons     = 0;
   logic        prev_acc = 1'b0;
   logic        prev_wr  = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Write logger: one entry per wr_en cycle, with the number of
   // bytes consumed before it and whether a byte was taken the
   // cycle just before.
   always @(negedge clk) begin
      #2;
      if (bus.wr_en) begin
         chk("wr_cycle_ready", bus.byte_ready, 0);
         wa.push_back(bus.wr_addr);
         wd.push_back(bus.wr_data);
         wc.push_back(cons);
         wp.push_back(prev_acc);
      end
      if (prev_wr && bus.byte_valid)
         chk("held_byte_taken", bus.byte_ready, 1);
      prev_wr  = bus.wr_en;
      prev_acc = bus.byte_valid && bus.byte_ready;
      if (prev_acc) cons++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic clr_log;
      wa.delete();
      wd.delete();
      wc.delete();
      wp.delete();
      cons = 0;
   endtask

   task automatic build_nom(input logic [7:0] c);
      stim = {8'h02, 8'h00, 8'h10, 8'h04, 8'h43,
              8'h00, 8'h20, 8'h10, 8'h25, c};
   endtask

   task automatic build_rand(input int n, input bit good);
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      stim.delete();
      stim.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) begin
         b = 8'($urandom);
         stim.push_back(b);
         x = x ^ b;
      end
      if (good) stim.push_back(x);
      else      stim.push_back(x ^ 8'($urandom_range(1, 255)));
   endtask

   task automatic pulse_start;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("hold_after_start", bus.cpu_hold, 1);
      chk("done_cleared", bus.done, 0);
      chk("err_cleared", bus.err, 0);
   endtask

   // Offer stim[0..cnt-1], each byte held until accepted.
   // inj >= 0 pulses start while byte inj is being offered.
   task automatic send(input bit gap, input int inj, input int cnt);
      int i   = 0;
      int cyc = 0;
      bit did = 1'b0;
      while (i < cnt && cyc < 4 * cnt + 64) begin
         @(negedge clk);
         bus.byte_in    = stim[i];
         bus.byte_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.start      = (i == inj) && !did;
         if (bus.start) did = 1'b1;
         #1;
         if (bus.byte_valid && bus.byte_ready) i++;
         cyc++;
      end
      chk("bytes_sent", i, cnt);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.start      = 1'b0;
   endtask

   task automatic run_load(input bit gap, input int inj);
      logic [7:0]  n;
      logic [7:0]  x;
      logic [31:0] w;
      bit          legal;
      bit          exp_done;
      int          nw;
      int          t;
      clr_log();
      pulse_start();
      send(gap, inj, stim.size());
      t = 0;
      while (!(bus.done || bus.err) && t < 20) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk("load_finished", bus.done | bus.err, 1);
      n     = stim[0];
      legal = (n >= 8'd1) && (int'(n) <= IMEM_DEPTH);
      nw    = legal ? int'(n) : 0;
      x     = 8'h00;
      chk("write_count", wa.size(), nw);
      for (int k = 0; k < nw; k++) begin
         w = {stim[1+4*k], stim[2+4*k], stim[3+4*k], stim[4+4*k]};
         x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         if (k < wa.size()) begin
            chk("wr_addr", wa[k], 32'(k * 4));
            chk("wr_data", wd[k], w);
            chk("wr_latency_bytes", wc[k], 1 + 4 * (k + 1));
            chk("wr_latency_prev", wp[k], 1);
         end
      end
      exp_done = legal && (stim[1+4*nw] == x);
      chk("done", bus.done, exp_done);
      chk("err", bus.err, !exp_done);
      chk("cpu_hold", bus.cpu_hold, !exp_done);
      chk("ready_at_end", bus.byte_ready, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_byte_ready", bus.byte_ready, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_cpu_hold", bus.cpu_hold, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      rst_n = 1'b1;

      build_nom(8'h42);
      run_load(1'b0, -1);

      build_nom(8'h43);
      run_load(1'b0, -1);
      build_nom(8'h42);
      run_load(1'b0, -1);

      stim = {8'h00};
      run_load(1'b0, -1);
      stim = {8'h41};
      run_load(1'b0, -1);

      build_rand(64, 1'b1);
      run_load(1'b0, -1);
      if (wa.size() > 0) chk("last_addr_fc", wa[wa.size()-1], 32'hFC);

      build_nom(8'h42);
      run_load(1'b1, -1);

      // Reset in the middle of the second word.
      build_nom(8'h42);
      clr_log();
      pulse_start();
      send(1'b0, -1, 6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_byte_ready", bus.byte_ready, 0);
      chk("mid_rst_wr_en", bus.wr_en, 0);
      chk("mid_rst_wr_addr", bus.wr_addr, 0);
      chk("mid_rst_wr_data", bus.wr_data, 0);
      chk("mid_rst_cpu_hold", bus.cpu_hold, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_err", bus.err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_log();
      bus.byte_in    = 8'h55;
      bus.byte_valid = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      chk("idle_no_consume", cons, 0);
      chk("idle_no_write", wa.size(), 0);
      chk("idle_hold", bus.cpu_hold, 0);
      bus.byte_valid = 1'b0;
      run_load(1'b0, -1);

      build_nom(8'h42);
      run_load(1'b0, 3);

      for (int r = 0; r < 8; r++) begin
         build_rand($urandom_range(1, 8), ($urandom_range(0, 2) != 0));
         run_load(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
